hilo_pipe: RTL and testbench

//  Downstream consumer of the execute-stage ALU HI/LO write bus (hilo_writeE/hilo_selectE/aluoutE).

---
 rtl/hilo_pipe_if.sv | 20 ++
 rtl/hilo_pipe.sv | 100 ++++++++++
 tb/tb_hilo_pipe.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_pipe_if.sv
// Execute-stage HI/LO write bus plus the MFHI/MFLO read port between the ALU side and hilo_pipe.
interface hilo_pipe_if #(parameter int HILO_W = 32);
  logic                  hilo_writeE;
  logic [1:0]            hilo_selectE;
  logic [2*HILO_W-1:0]   aluoutE;
  logic                  rd_reqE;
  logic                  rd_hiE;
  logic [HILO_W-1:0]     rdataE;
  logic                  hilo_stallE;

  modport master (
    output hilo_writeE, hilo_selectE, aluoutE, rd_reqE, rd_hiE,
    input  rdataE, hilo_stallE
  );

  modport slave (
    input  hilo_writeE, hilo_selectE, aluoutE, rd_reqE, rd_hiE,
    output rdataE, hilo_stallE
  );
endinterface

// File: rtl/hilo_pipe.sv
// HI/LO write pipeline (M, W slots) committing to architectural HI/LO 3 edges after E; stallM/stallW hold slots.
// `HILO_FWD_EN: forward M/W writes to the E read; otherwise raise hilo_stallE until the write commits.
module hilo_pipe #(
  parameter int                 HILO_W = 32,
  parameter logic [HILO_W-1:0]  RST_HI = '0,
  parameter logic [HILO_W-1:0]  RST_LO = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallM,
  input  logic               stallW,
  input  logic               flushM,
  input  logic               flushW,
  hilo_pipe_if.slave         bus,
  output logic [HILO_W-1:0]  hi_o,
  output logic [HILO_W-1:0]  lo_o
);

  typedef struct packed {
    logic              v;
    logic              we_hi;
    logic              we_lo;
    logic [HILO_W-1:0] hi;
    logic [HILO_W-1:0] lo;
  } slot_t;

  slot_t slot_e;
  slot_t slot_m;
  slot_t slot_w;

  logic  hit_m;
  logic  hit_w;
  logic  [HILO_W-1:0] arch_rd;

  always_comb begin
    slot_e       = '0;
    slot_e.v     = bus.hilo_writeE;
    slot_e.we_hi = bus.hilo_writeE & (~bus.hilo_selectE[1] | bus.hilo_selectE[0]);
    slot_e.we_lo = bus.hilo_writeE & (~bus.hilo_selectE[1] | ~bus.hilo_selectE[0]);
    slot_e.hi    = bus.aluoutE[2*HILO_W-1:HILO_W];
    slot_e.lo    = bus.aluoutE[HILO_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_m <= '0;
      slot_w <= '0;
      hi_o   <= RST_HI;
      lo_o   <= RST_LO;
    end else begin
      if (flushM) begin
        slot_m.v <= 1'b0;
      end else if (!stallM) begin
        slot_m <= slot_e;
      end

      // A flushed or stalled M occupant must not advance into W.
      if (flushW) begin
        slot_w.v <= 1'b0;
      end else if (!stallW) begin
        slot_w   <= slot_m;
        slot_w.v <= slot_m.v & ~stallM & ~flushM;
      end

      if (slot_w.v && !stallW && !flushW) begin
        if (slot_w.we_hi) hi_o <= slot_w.hi;
        if (slot_w.we_lo) lo_o <= slot_w.lo;
      end
    end
  end

  // Slots being flushed this cycle are already dead and must not be seen by the read.
  always_comb begin
    hit_m   = slot_m.v & ~flushM & (bus.rd_hiE ? slot_m.we_hi : slot_m.we_lo);
    hit_w   = slot_w.v & ~flushW & (bus.rd_hiE ? slot_w.we_hi : slot_w.we_lo);
    arch_rd = bus.rd_hiE ? hi_o : lo_o;
  end

`ifdef HILO_FWD_EN
  logic unused_rd_req;
  assign unused_rd_req = bus.rd_reqE;

  always_comb begin
    bus.hilo_stallE = 1'b0;
    if (hit_m) begin
      bus.rdataE = bus.rd_hiE ? slot_m.hi : slot_m.lo;
    end else if (hit_w) begin
      bus.rdataE = bus.rd_hiE ? slot_w.hi : slot_w.lo;
    end else begin
      bus.rdataE = arch_rd;
    end
  end
`else
  always_comb begin
    bus.rdataE      = arch_rd;
    bus.hilo_stallE = bus.rd_reqE & (hit_m | hit_w);
  end
`endif

endmodule

// File: tb/tb_hilo_pipe.sv
// Directed + random bench for hilo_pipe against an in-bench model of pending HI/LO writes.
module tb_hilo_pipe;
  logic clk = 1'b0;
  logic rst, stallM, stallW, flushM, flushW;
  logic [31:0] hi_o, lo_o;

  always #5 clk = ~clk;

  hilo_pipe_if #(.HILO_W(32)) bus ();

  hilo_pipe #(.HILO_W(32), .RST_HI(32'h0), .RST_LO(32'h0)) dut (
    .clk    (clk),
    .rst    (rst),
    .stallM (stallM),
    .stallW (stallW),
    .flushM (flushM),
    .flushW (flushW),
    .bus    (bus),
    .hi_o   (hi_o),
    .lo_o   (lo_o)
  );

  typedef struct {
    bit          v;
    bit          wh;
    bit          wl;
    logic [31:0] h;
    logic [31:0] l;
  } pend_t;

  // pend[0] is the write in M (youngest), pend[1] the write in W.
  pend_t       pend [2];
  logic [31:0] arch_hi, arch_lo;
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit live(input int i, input bit hi);
    bit killed;
    killed = (i == 0) ? flushM : flushW;
    return pend[i].v && !killed && (hi ? pend[i].wh : pend[i].wl);
  endfunction

  function automatic logic [31:0] exp_rdata(input bit hi);
    logic [31:0] r;
    r = hi ? arch_hi : arch_lo;
`ifdef HILO_FWD_EN
    for (int i = 1; i >= 0; i--)
      if (live(i, hi)) r = hi ? pend[i].h : pend[i].l;
`endif
    return r;
  endfunction

  function automatic logic exp_stall(input bit req, input bit hi);
`ifdef HILO_FWD_EN
    return 1'b0;
`else
    return req && (live(0, hi) || live(1, hi));
`endif
  endfunction

  task automatic model_edge();
    pend_t e;
    pend_t old_m;
    if (rst) begin
      arch_hi = 32'h0;
      arch_lo = 32'h0;
      pend[0].v = 1'b0;
      pend[1].v = 1'b0;
      return;
    end
    if (pend[1].v && !stallW && !flushW) begin
      if (pend[1].wh) arch_hi = pend[1].h;
      if (pend[1].wl) arch_lo = pend[1].l;
    end
    e.v = bus.hilo_writeE;
    e.h = bus.aluoutE[63:32];
    e.l = bus.aluoutE[31:0];
    case (bus.hilo_selectE)
      2'b11:   begin e.wh = 1'b1; e.wl = 1'b0; end
      2'b10:   begin e.wh = 1'b0; e.wl = 1'b1; end
      default: begin e.wh = 1'b1; e.wl = 1'b1; end
    endcase
    if (!e.v) begin e.wh = 1'b0; e.wl = 1'b0; end
    old_m = pend[0];
    if (flushM)       pend[0].v = 1'b0;
    else if (!stallM) pend[0]   = e;
    if (flushW)       pend[1].v = 1'b0;
    else if (!stallW) begin
      pend[1]   = old_m;
      pend[1].v = old_m.v && !stallM && !flushM;
    end
  endtask

  task automatic drive(input bit we, input logic [1:0] sel, input logic [63:0] alu,
                       input bit rq, input bit rh, input bit sm, input bit sw,
                       input bit fm, input bit fw, input bit r);
    bus.hilo_writeE  = we;
    bus.hilo_selectE = sel;
    bus.aluoutE      = alu;
    bus.rd_reqE      = rq;
    bus.rd_hiE       = rh;
    stallM = sm; stallW = sw; flushM = fm; flushW = fw; rst = r;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cycle();
    #1;
    chk("rdataE", bus.rdataE, exp_rdata(bus.rd_hiE));
    chk("hilo_stallE", {31'h0, bus.hilo_stallE}, {31'h0, exp_stall(bus.rd_reqE, bus.rd_hiE)});
    @(posedge clk);
    model_edge();
    #1;
    chk("hi_o", hi_o, arch_hi);
    chk("lo_o", lo_o, arch_lo);
    @(negedge clk);
  endtask

  initial begin
    int stalls;
    logic [31:0] keep_hi, keep_lo;

    // Bring the DUT out of its unknown power-up state before checking.
    pend[0] = '{default: '0};
    pend[1] = '{default: '0};
    idle();
    rst = 1'b1;
    @(posedge clk);
    model_edge();
    @(negedge clk);

    // 1: reset state
    idle(); rst = 1'b1; bus.rd_reqE = 1'b1; bus.rd_hiE = 1'b1;
    cycle();
    idle(); bus.rd_reqE = 1'b1; bus.rd_hiE = 1'b1;
    #1;
    chk("t1_rd_hi", bus.rdataE, 32'h0);
    chk("t1_stall", {31'h0, bus.hilo_stallE}, 32'h0);
    cycle();
    idle(); bus.rd_reqE = 1'b1; bus.rd_hiE = 1'b0;
    #1;
    chk("t1_rd_lo", bus.rdataE, 32'h0);
    cycle();

    // 2: MULT lands in arch on the 3rd edge
    drive(1'b1, 2'b00, 64'h00000001_FFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    idle(); cycle();
    chk("t2_hi_early", hi_o, 32'h0);
    cycle();
    chk("t2_hi", hi_o, 32'h1);
    chk("t2_lo", lo_o, 32'hFFFFFFFE);

    // 3: MTHI then read HI next cycle
    drive(1'b1, 2'b11, {32'hDEADBEEF, 32'h12345678}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    idle(); bus.rd_reqE = 1'b1; bus.rd_hiE = 1'b1;
`ifdef HILO_FWD_EN
    #1;
    chk("t3_fwd", bus.rdataE, 32'hDEADBEEF);
    cycle();
    idle(); cycle(); cycle();
`else
    stalls = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (!bus.hilo_stallE) break;
      stalls++;
      cycle();
    end
    chk("t3_stall_cycles", stalls, 2);
    chk("t3_rd", bus.rdataE, 32'hDEADBEEF);
    cycle();
`endif
    chk("t3_lo_kept", lo_o, 32'hFFFFFFFE);
    chk("t3_hi", hi_o, 32'hDEADBEEF);

    // 4: back-to-back MTLO, youngest wins
    drive(1'b1, 2'b10, 64'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 2'b10, 64'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    idle(); bus.rd_reqE = 1'b1; bus.rd_hiE = 1'b0;
    #1;
`ifdef HILO_FWD_EN
    chk("t4_fwd", bus.rdataE, 32'h22);
`else
    chk("t4_stall", {31'h0, bus.hilo_stallE}, 32'h1);
`endif
    cycle();
    idle(); cycle(); cycle(); cycle();
    chk("t4_lo", lo_o, 32'h22);

    // 5: flushM and flushW kill in-flight writes
    keep_hi = hi_o; keep_lo = lo_o;
    drive(1'b1, 2'b00, {32'h7, 32'h3}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    idle(); flushM = 1'b1; cycle();
    idle(); cycle(); cycle(); cycle();
    chk("t5_flushM_hi", hi_o, keep_hi);
    chk("t5_flushM_lo", lo_o, keep_lo);
    drive(1'b1, 2'b11, {32'h55, 32'h0}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    idle(); cycle();
    idle(); flushW = 1'b1; cycle();
    idle(); cycle(); cycle();
    chk("t5_flushW_hi", hi_o, keep_hi);

    // 6: stallM bubbles W; reset mid-flight clears everything
    drive(1'b1, 2'b10, 64'h99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    idle(); stallM = 1'b1; cycle(); cycle(); cycle();
    chk("t6_held", lo_o, 32'h22);
    idle(); cycle(); cycle(); cycle();
    chk("t6_lo", lo_o, 32'h99);
    drive(1'b1, 2'b00, {32'h77, 32'h88}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    idle(); rst = 1'b1; stallM = 1'b1; stallW = 1'b1; cycle();
    idle(); cycle(); cycle(); cycle();
    chk("t6_rst_hi", hi_o, 32'h0);
    chk("t6_rst_lo", lo_o, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic sw_r;
      sw_r = ($urandom_range(0, 7) == 0);
      drive($urandom_range(0, 1) == 1,
            2'($urandom_range(0, 3)),
            {$urandom, $urandom},
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1,
            sw_r || ($urandom_range(0, 3) == 0),
            sw_r,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 59) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
